dram_read_arbiter: RTL

Shares the single DRAM read port (AXI-style info/data channels) among NUM_REQ reference readers, so several Smith-Waterman engines can fetch reference blocks concurrently. Read requests are granted round-robin and forwarded one at a time. Memory returns bursts in issue order. The block tracks each issued burst's owner and length in a FIFO and steers returning 256-bit beats to the owning requester.

---
 rtl/dram_rd_arb_pkg.sv | 22 ++
 rtl/read_track_fifo.sv | 71 +++++++
 rtl/dram_read_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dram_rd_arb_pkg.sv
// Shared definitions for the DRAM read arbiter.
// Holds the default channel widths, the requester index width, the width of
// one burst-tracking entry ({owner, len}) and the info FSM state encoding.
package dram_rd_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ID_WIDTH    = 6;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_LEN_WIDTH   = 8;
  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_TRACK_DEPTH = 8;

  localparam int IDX_WIDTH         = $clog2(DEF_NUM_REQ);
  localparam int TRACK_ENTRY_WIDTH = IDX_WIDTH + DEF_LEN_WIDTH;

  // Info channel FSM: IDLE looks for a grant, ISSUE holds the burst on the bus.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } info_state_e;

endpackage

// File: rtl/read_track_fifo.sv
// Synchronous FIFO holding one {owner, len} entry per issued read burst.
// Ports:
//   clk, rst          clock, synchronous active-low reset (empties the FIFO)
//   push_in/_data_in  write one entry (ignored when full)
//   pop_in            drop the head entry (ignored when empty)
//   head_data_out     current head entry, valid when !empty_out
//   full_out/empty_out/count_out  status and occupancy
module read_track_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_in,
  input  logic [WIDTH-1:0]         push_data_in,
  input  logic                     pop_in,
  output logic [WIDTH-1:0]         head_data_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_out      = (count_q == CNT_W'(DEPTH));
  assign empty_out     = (count_q == '0);
  assign count_out     = count_q;
  assign head_data_out = mem_q[rd_ptr_q];

  assign do_push = push_in && !full_out;
  assign do_pop  = pop_in && !empty_out;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_in;
  end

endmodule

// File: rtl/dram_read_arbiter.sv
// Shares one DRAM read port among NUM_REQ reference readers.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   req_id/addr/len_in            per-requester burst info, slice i = requester i
//   req_info_valid_in/_rdy_out    request handshake; rdy is a one-hot grant pulse
//   req_data_out                  read data broadcast to all requesters
//   req_data_valid_out/_rdy_in    one-hot data valid to the burst owner, owner ready
//   rd_id/addr/len_out            burst info to the bus (registered)
//   rd_info_valid_out/_rdy_in     bus info handshake
//   rd_data_in/_valid_in/_rdy_out bus read data handshake
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; valid/info stay stable until then, ready may depend combinationally on
// valid only on the requester-info side (the grant pulse).
// Requests are granted round-robin, one burst in flight on the info channel at
// a time. Bursts return in issue order, so an {owner, len} FIFO is enough to
// steer every returning beat; the burst ID is passed through but never used.
import dram_rd_arb_pkg::*;

module dram_read_arbiter #(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TRACK_DEPTH = DEF_TRACK_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ID_WIDTH-1:0]   req_id_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len_in,
  input  logic [NUM_REQ-1:0]            req_info_valid_in,
  output logic [NUM_REQ-1:0]            req_info_rdy_out,
  output logic [DATA_WIDTH-1:0]         req_data_out,
  output logic [NUM_REQ-1:0]            req_data_valid_out,
  input  logic [NUM_REQ-1:0]            req_data_rdy_in,
  output logic [ID_WIDTH-1:0]           rd_id_out,
  output logic [ADDR_WIDTH-1:0]         rd_addr_out,
  output logic [LEN_WIDTH-1:0]          rd_len_out,
  output logic                          rd_info_valid_out,
  input  logic                          rd_info_rdy_in,
  input  logic [DATA_WIDTH-1:0]         rd_data_in,
  input  logic                          rd_data_valid_in,
  output logic                          rd_data_rdy_out
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int ENTRY_W = IDX_W + LEN_WIDTH;
  localparam int CNT_W   = $clog2(TRACK_DEPTH) + 1;

  info_state_e           state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  vld_q, vld_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand;
  logic                  can_grant;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic [IDX_W-1:0]      head_owner;
  logic [LEN_WIDTH-1:0]  head_len;
  logic                  beat_hs;

  // First valid requester at or after the pointer, scanning cyclically.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!grant_found && req_info_valid_in[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Occupancy counts pushed entries only; since at most one granted burst is
  // waiting for its push, checking here guarantees the later push has room.
  // The grant pulse is suppressed while reset is asserted, as the grant would
  // be discarded at that edge anyway.
  assign can_grant = rst && (state_q == ST_IDLE) && grant_found &&
                     (fifo_count < CNT_W'(TRACK_DEPTH));

  assign req_info_rdy_out = can_grant ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    vld_d     = vld_q;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          id_d    = req_id_in[grant_idx*ID_WIDTH +: ID_WIDTH];
          addr_d  = req_addr_in[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          len_d   = req_len_in[grant_idx*LEN_WIDTH +: LEN_WIDTH];
          owner_d = grant_idx;
          ptr_d   = grant_idx + IDX_W'(1);
          vld_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rd_info_rdy_in) begin
          fifo_push = 1'b1;
          vld_d     = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rd_id_out         = id_q;
  assign rd_addr_out       = addr_q;
  assign rd_len_out        = len_q;
  assign rd_info_valid_out = vld_q;

  // Data steering from the FIFO head.
  assign head_owner = fifo_head[ENTRY_W-1 -: IDX_W];
  assign head_len   = fifo_head[LEN_WIDTH-1:0];

  assign req_data_out       = rd_data_in;
  assign rd_data_rdy_out    = !fifo_empty && req_data_rdy_in[head_owner];
  assign req_data_valid_out = fifo_empty ? '0
                                         : (NUM_REQ'(rd_data_valid_in) << head_owner);

  assign beat_hs  = rd_data_valid_in && rd_data_rdy_out;
  // Last beat pops at this edge, so the next beat already sees the new head.
  assign fifo_pop = beat_hs && (beat_cnt_q == head_len);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat_hs) beat_cnt_d = fifo_pop ? '0 : beat_cnt_q + LEN_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      vld_q      <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      vld_q      <= vld_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  read_track_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (TRACK_DEPTH)
  ) u_track (
    .clk           (clk),
    .rst           (rst),
    .push_in       (fifo_push && !fifo_full),
    .push_data_in  ({owner_q, len_q}),
    .pop_in        (fifo_pop),
    .head_data_out (fifo_head),
    .full_out      (fifo_full),
    .empty_out     (fifo_empty),
    .count_out     (fifo_count)
  );

endmodule
